// File: rtl/proc_pkg.sv
// Shared processor definitions: address/word widths and the fetch-queue entry record.
package proc_pkg;

   localparam int unsigned AW_DEF = 16;
   localparam int unsigned WORD_W = 16;

   // Field order matches the packing used for queue storage.
   typedef struct packed {
      logic [WORD_W-1:0] fncode;
      logic [WORD_W-1:0] data;
      logic [AW_DEF-1:0] addr;
   } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Fetch-queue storage: register array with one synchronous write port and one async read port.
module fq_ram #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 48
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   // Contents need no reset; occupancy tracking in the controller qualifies every read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: streams words from synchronous program memory into a small FIFO
// feeding the execute FSM, with redirect flush and halt stall.
module fetch_queue
   import proc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     halt,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_addr,
   output logic [AW-1:0]            mem_addr,
   input  logic [WORD_W-1:0]        mem_fncode,
   input  logic [WORD_W-1:0]        mem_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_W-1:0]        out_fncode,
   output logic [WORD_W-1:0]        out_data,
   output logic [AW-1:0]            out_addr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = CW + 1;
   localparam int unsigned EW = 2 * WORD_W + AW;

   logic [AW-1:0] pc;
   logic [AW-1:0] tag;
   logic          inflight;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;

   logic          pop;
   logic          push;
   logic          issue;
   logic [OW-1:0] occ;
   logic [EW-1:0] wdata;
   logic [EW-1:0] rdata;

   // Handshake and issue decisions; a redirect cycle neither pops nor fetches.
   assign out_valid = (cnt != '0);
   assign pop       = out_valid && out_ready && !redirect;
   assign push      = inflight && !redirect;
   assign occ       = OW'(cnt) + OW'(inflight);
   assign issue     = !halt && !redirect && ((occ < OW'(DEPTH)) || (out_valid && out_ready));
   assign mem_addr  = pc;

   // Fetch pointer and one-deep in-flight tracker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= '0;
         tag      <= '0;
         inflight <= 1'b0;
      end else if (redirect) begin
         pc       <= redirect_addr;
         inflight <= 1'b0;
      end else if (issue) begin
         pc       <= pc + AW'(1);
         tag      <= pc;
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (redirect) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   assign wdata = {mem_fncode, mem_data, tag};

   fq_ram #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (tail),
      .wdata (wdata),
      .raddr (head),
      .rdata (rdata)
   );

   // Head entry is forced to zero while empty so stale storage never shows.
   assign out_fncode = out_valid ? rdata[EW-1 -: WORD_W]      : '0;
   assign out_data   = out_valid ? rdata[AW+WORD_W-1 -: WORD_W] : '0;
   assign out_addr   = out_valid ? rdata[AW-1:0]              : '0;
   assign count      = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios push expected head entries,
// a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_queue;

   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          halt = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_fncode = '0;
   logic [15:0]   mem_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_fncode;
   logic [15:0]   out_data;
   logic [AW-1:0] out_addr;
   logic [2:0]    count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [AW-1:0] exp_q[$];

   fetch_queue #(.DEPTH(4), .AW(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .halt          (halt),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .mem_addr      (mem_addr),
      .mem_fncode    (mem_fncode),
      .mem_data      (mem_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_fncode    (out_fncode),
      .out_data      (out_data),
      .out_addr      (out_addr),
      .count         (count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] fn_of(input logic [AW-1:0] a);
      return a ^ 16'hC3C3;
   endfunction

   // Synchronous program memory: word at address n is n.
   always @(posedge clk) begin
      mem_data   <= mem_addr;
      mem_fncode <= fn_of(mem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare each accepted head entry against the scoreboard.
   always @(negedge clk) begin
      if (!rst && !redirect && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop_addr", 32'(out_addr), 32'hFFFF_FFFF);
         end else begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            check("pop_addr", 32'(out_addr), 32'(e));
            check("pop_data", 32'(out_data), 32'(e));
            check("pop_fncode", 32'(out_fncode), 32'(fn_of(e)));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; halt = 1'b0; redirect = 1'b0; out_ready = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain(input int budget, input bit chk_valid, output int cycles);
      out_ready = 1'b1;
      cycles = 0;
      while (exp_q.size() != 0 && cycles < budget) begin
         @(posedge clk); #1;
         cycles++;
         if (chk_valid && cycles >= 2 && exp_q.size() != 0)
            check("valid_held", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b0;
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cyc;

      // Reset state
      #12;
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);

      // Free run: ten entries, one per cycle after a two-cycle fill
      do_reset();
      for (int i = 0; i < 10; i++) exp_q.push_back(AW'(i));
      drain(40, 1'b1, cyc);
      check("freerun_cycles", 32'(cyc), 32'd12);

      // Back-pressure saturation
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
      repeat (10) begin @(posedge clk); #1; end
      check("full_count", 32'(count), 32'd4);
      check("full_mem_addr", 32'(mem_addr), 32'd4);
      check("full_head", 32'(out_addr), 32'd0);
      drain(20, 1'b0, cyc);

      // Redirect with a nearly full queue and a fetch in flight
      do_reset();
      exp_q.push_back(AW'(0));
      exp_q.push_back(AW'(1));
      for (int i = 0; i < 3; i++) exp_q.push_back(AW'(16'h0100 + i));
      repeat (10) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_redirect_count", 32'(count), 32'd3);
      redirect = 1'b1; redirect_addr = 16'h0100;
      @(posedge clk); #1;
      redirect = 1'b0;
      check("redir_count", 32'(count), 32'd0);
      check("redir_valid", 32'(out_valid), 32'd0);
      check("redir_mem_addr", 32'(mem_addr), 32'h0100);
      drain(20, 1'b0, cyc);

      // Address wrap
      do_reset();
      redirect = 1'b1; redirect_addr = 16'hFFFF;
      @(posedge clk); #1;
      redirect = 1'b0;
      check("wrap_mem_addr", 32'(mem_addr), 32'hFFFF);
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      drain(20, 1'b0, cyc);

      // Halt with a fetch in flight
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
      repeat (3) begin @(posedge clk); #1; end
      check("halt_pre_count", 32'(count), 32'd2);
      halt = 1'b1;
      @(posedge clk); #1;
      check("halt_count", 32'(count), 32'd3);
      check("halt_mem_addr", 32'(mem_addr), 32'd3);
      repeat (3) begin @(posedge clk); #1; end
      check("halt_hold_count", 32'(count), 32'd3);
      check("halt_hold_mem_addr", 32'(mem_addr), 32'd3);
      halt = 1'b0;
      @(posedge clk); #1;
      check("resume_mem_addr", 32'(mem_addr), 32'd4);
      @(posedge clk); #1;
      check("resume_count", 32'(count), 32'd4);
      drain(20, 1'b0, cyc);

      // Asynchronous reset between edges
      do_reset();
      repeat (4) begin @(posedge clk); #1; end
      check("pre_arst_count", 32'(count), 32'd3);
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("arst_count", 32'(count), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_out_addr", 32'(out_addr), 32'd0);
      check("arst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(AW'(0));
      exp_q.push_back(AW'(1));
      drain(20, 1'b0, cyc);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
